// File: rtl/ysyx_23060042_pkg.sv
// Shared types and constants for the ysyx_23060042 core front end.
package ysyx_23060042_pkg;

    // Fetch FSM: address phase, data phase, hand to IDU, wait for retirement.
    typedef enum logic [1:0] {
        S_AR  = 2'd0,
        S_R   = 2'd1,
        S_OUT = 2'd2,
        S_WB  = 2'd3
    } ifu_state_e;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] INST_EBREAK      = 32'h0010_0073;
    localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // A jump target is usable only if it lands on a 4-byte boundary.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/ysyx_23060042_ifu.sv
// Instruction fetch unit: one AXI4-Lite read per instruction, one instruction
// in flight, result handed to the IDU and the next PC taken from write-back.
module ysyx_23060042_ifu
    import ysyx_23060042_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              fetch_err,
    input  logic [ADDR_W-1:0] dnpc,
    input  logic              dnpc_valid,
    output logic              dnpc_ready
);

    ifu_state_e        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_inst;
    logic              r_err;

    ifu_state_e        w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [31:0]       w_inst_nxt;
    logic              w_err_nxt;

    // Next-state and register-update logic; everything holds unless a handshake fires.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_inst_nxt  = r_inst;
        w_err_nxt   = r_err;
        case (r_state)
            S_AR: begin
                // arvalid is high for the whole state, so arready alone completes it.
                if (arready) begin
                    w_state_nxt = S_R;
                end else begin
                    w_state_nxt = S_AR;
                end
            end
            S_R: begin
                if (rvalid) begin
                    if (rresp == AXI_RESP_OKAY) begin
                        w_inst_nxt = rdata;
                        w_err_nxt  = 1'b0;
                    end else begin
                        // A bus fault becomes a trap the rest of the pipeline already handles.
                        w_inst_nxt = INST_EBREAK;
                        w_err_nxt  = 1'b1;
                    end
                    w_state_nxt = S_OUT;
                end else begin
                    w_state_nxt = S_R;
                end
            end
            S_OUT: begin
                if (inst_ready) begin
                    w_state_nxt = S_WB;
                end else begin
                    w_state_nxt = S_OUT;
                end
            end
            S_WB: begin
                if (dnpc_valid) begin
                    if (is_word_aligned(dnpc[1:0])) begin
                        w_pc_nxt    = dnpc;
                        w_state_nxt = S_AR;
                    end else begin
                        // Misaligned target: never fetch it, report a trap at the old pc.
                        w_inst_nxt  = INST_EBREAK;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_OUT;
                    end
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            default: begin
                w_state_nxt = S_AR;
            end
        endcase
    end

    // State, pc, instruction and fault registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_AR;
            r_pc    <= RESET_PC;
            r_inst  <= INST_NOP;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_inst  <= w_inst_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Outputs depend only on registered state, never on an input.
    assign araddr     = r_pc;
    assign pc         = r_pc;
    assign inst       = r_inst;
    assign fetch_err  = r_err;
    assign arvalid    = (r_state == S_AR);
    assign rready     = (r_state == S_R);
    assign inst_valid = (r_state == S_OUT);
    assign dnpc_ready = (r_state == S_WB);

endmodule
